// File: rtl/pending_request_encoder_pkg.sv
// Shared definitions for the pending request encoder: FSM state encoding
// and selection policy constants.
package pending_request_encoder_pkg;

    // The handshake FSM alternates between looking for work and presenting it.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Selection policy values for the RR_MODE parameter.
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

endpackage

// File: rtl/pending_request_encoder_pick.sv
// Combinational find-first-set: returns the lowest set index of vec and a
// flag telling whether any bit was set. idx is 0 when nothing is found.
module prio_pick_lsb #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pending_request_encoder.sv
// Registered priority encoder: request pulses are captured into sticky
// pending bits, one eligible index is selected (fixed priority or
// round-robin) and offered on a valid/ready handshake. The served pending
// bit is cleared on acceptance unless it is re-requested in that same cycle.
module pending_request_encoder
    import pending_request_encoder_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int RR_MODE = MODE_FIXED,
    localparam int W       = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] REQ_IN,
    input  logic [N-1:0] MASK,
    output logic [W-1:0] OUT_IDX,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [N-1:0] PENDING,
    output logic         DUP_REQ
);

    state_t       state;
    state_t       state_nxt;

    logic [N-1:0] pending;
    logic [N-1:0] pending_nxt;
    logic [N-1:0] clr;
    logic [N-1:0] elig;
    logic [N-1:0] below_ptr;
    logic [N-1:0] elig_upper;

    logic [W-1:0] out_idx;
    logic [W-1:0] idx_nxt;
    logic [W-1:0] rr_ptr;
    logic [W-1:0] rr_nxt;
    logic [W-1:0] up_idx;
    logic [W-1:0] wrap_idx;
    logic [W-1:0] sel_idx;

    logic         out_valid;
    logic         valid_nxt;
    logic         dup_req;
    logic         dup_nxt;
    logic         up_found;
    logic         wrap_found;
    logic         accept;

    // A transfer happens only while an index is actually being presented.
    assign accept = out_valid & OUT_READY;

    // One-hot clear of the index being accepted this cycle.
    always_comb begin
        clr = '0;
        if (accept) begin
            clr[out_idx] = 1'b1;
        end
    end

    // New requests are ORed in after the clear so a same-cycle re-request
    // keeps the bit set; a request landing on a bit that stays pending is a
    // duplicate.
    assign pending_nxt = (pending & ~clr) | REQ_IN;
    assign dup_nxt     = |(REQ_IN & pending & ~clr);

    // Masked channels keep their pending bit but cannot be selected.
    assign elig = pending & ~MASK;

    // Channels strictly below the round-robin pointer form the wrap region.
    always_comb begin
        below_ptr = '0;
        for (int i = 0; i < N; i++) begin
            below_ptr[i] = (W'(i) < rr_ptr);
        end
    end

    assign elig_upper = elig & ~below_ptr;

    prio_pick_lsb #(.N(N)) u_pick_upper (
        .vec   (elig_upper),
        .idx   (up_idx),
        .found (up_found)
    );

    prio_pick_lsb #(.N(N)) u_pick_wrap (
        .vec   (elig),
        .idx   (wrap_idx),
        .found (wrap_found)
    );

    // Round-robin prefers channels at or after the pointer and falls back to
    // the lowest eligible channel; fixed priority always takes the lowest.
    assign sel_idx = ((RR_MODE == MODE_RR) && up_found) ? up_idx : wrap_idx;

    // Next-state logic: select in IDLE, hold the offer stable until accepted.
    always_comb begin
        state_nxt = state;
        idx_nxt   = out_idx;
        valid_nxt = out_valid;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (wrap_found) begin
                    idx_nxt   = sel_idx;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (OUT_READY) begin
                    valid_nxt = 1'b0;
                    rr_nxt    = (out_idx == W'(N - 1)) ? '0 : out_idx + W'(1);
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // FSM, presented index and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_idx   <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            out_idx   <= idx_nxt;
            out_valid <= valid_nxt;
            rr_ptr    <= rr_nxt;
        end
    end

    // Sticky pending vector and the duplicate-request pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            dup_req <= 1'b0;
        end else begin
            pending <= pending_nxt;
            dup_req <= dup_nxt;
        end
    end

    assign OUT_IDX   = out_idx;
    assign OUT_VALID = out_valid;
    assign PENDING   = pending;
    assign DUP_REQ   = dup_req;

endmodule
